// File: rtl/mux_8_32_if.sv
// Byte-in / word-out bus of the receive-path packer.
// The master drives bytes in; the slave (the packer) drives the word side.
interface mux_8_32_if;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        partial_drop;
    logic [7:0]  word_count;

    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, partial_drop, word_count
    );

    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, partial_drop, word_count
    );
endinterface

// File: rtl/mux_8_32.sv
// Byte-to-word packer for the PHY receive path (clk_4f domain).
// Four consecutive valid bytes form one word, first byte most significant.
module mux_8_32 (
    input  logic        clk_4f,
    input  logic        reset,
    mux_8_32_if.slave   bus
);

    logic [1:0]  sel_q, sel_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        partial_drop_q, partial_drop_d;
    logic [7:0]  word_count_q, word_count_d;

    always_comb begin
        sel_d          = sel_q;
        acc_d          = acc_q;
        data_out_d     = data_out_q;
        valid_out_d    = 1'b0;
        partial_drop_d = 1'b0;
        word_count_d   = word_count_q;

        // data_in is only looked at under valid_in, so X on idle cycles stays out
        if (bus.valid_in) begin
            case (sel_q)
                2'd0: begin
                    acc_d[23:16] = bus.data_in;
                    sel_d        = 2'd1;
                end
                2'd1: begin
                    acc_d[15:8] = bus.data_in;
                    sel_d       = 2'd2;
                end
                2'd2: begin
                    acc_d[7:0] = bus.data_in;
                    sel_d      = 2'd3;
                end
                2'd3: begin
                    data_out_d   = {acc_q, bus.data_in};
                    valid_out_d  = 1'b1;
                    word_count_d = word_count_q + 8'd1;
                    sel_d        = 2'd0;
                end
            endcase
        end else if (sel_q != 2'd0) begin
            partial_drop_d = 1'b1;
            sel_d          = 2'd0;
            acc_d          = 24'd0;
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            sel_q          <= 2'd0;
            acc_q          <= 24'd0;
            data_out_q     <= 32'd0;
            valid_out_q    <= 1'b0;
            partial_drop_q <= 1'b0;
            word_count_q   <= 8'd0;
        end else begin
            sel_q          <= sel_d;
            acc_q          <= acc_d;
            data_out_q     <= data_out_d;
            valid_out_q    <= valid_out_d;
            partial_drop_q <= partial_drop_d;
            word_count_q   <= word_count_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.partial_drop = partial_drop_q;
    assign bus.word_count   = word_count_q;

endmodule

// File: tb/tb_mux_8_32.sv
// Directed and randomized bench for mux_8_32 against a queue-based byte model.
module tb_mux_8_32;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    mux_8_32_if ifc ();

    mux_8_32 dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (ifc.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: collected bytes of the current group plus expected outputs.
    logic [7:0]  grp[$];
    logic [31:0] m_data = 32'd0;
    logic        m_vo   = 1'b0;
    logic        m_pd   = 1'b0;
    int          m_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"},     ifc.data_out,              m_data);
        check({tag, ".valid_out"},    {31'd0, ifc.valid_out},    {31'd0, m_vo});
        check({tag, ".partial_drop"}, {31'd0, ifc.partial_drop}, {31'd0, m_pd});
        check({tag, ".word_count"},   {24'd0, ifc.word_count},   m_cnt);
        check({tag, ".exclusive"},    {31'd0, ifc.valid_out & ifc.partial_drop}, 32'd0);
    endtask

    task automatic model_reset();
        grp.delete();
        m_data = 32'd0;
        m_vo   = 1'b0;
        m_pd   = 1'b0;
        m_cnt  = 0;
    endtask

    // One clk_4f cycle: drive, clock, update model, compare 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input string tag);
        ifc.valid_in = v;
        ifc.data_in  = v ? d : 8'hxx;
        @(posedge clk_4f);
        m_vo = 1'b0;
        m_pd = 1'b0;
        if (v) begin
            grp.push_back(d);
            if (grp.size() == 4) begin
                m_data = {grp[0], grp[1], grp[2], grp[3]};
                m_vo   = 1'b1;
                m_cnt  = (m_cnt + 1) % 256;
                grp.delete();
            end
        end else if (grp.size() != 0) begin
            m_pd = 1'b1;
            grp.delete();
        end
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, confirm outputs clear without an edge, release between edges.
    task automatic async_reset(input string tag);
        @(negedge clk_4f);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk_4f);
        @(negedge clk_4f);
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        ifc.valid_in = 1'b0;
        ifc.data_in  = 8'hxx;

        #3;
        check_all("por");
        @(negedge clk_4f);
        reset = 1'b0;

        // Single word
        step(1'b1, 8'hAA, "single");
        step(1'b1, 8'hBB, "single");
        step(1'b1, 8'hCC, "single");
        check({"single.no_early_vo"}, {31'd0, ifc.valid_out}, 32'd0);
        step(1'b1, 8'hDD, "single");
        check("single.word", ifc.data_out, 32'hAABBCCDD);
        check("single.vo", {31'd0, ifc.valid_out}, 32'd1);
        check("single.cnt", {24'd0, ifc.word_count}, 32'd1);
        step(1'b0, 8'h00, "single.idle");
        check("single.vo_drop", {31'd0, ifc.valid_out}, 32'd0);

        // Async reset mid-operation, then continuous stream
        step(1'b1, 8'h5A, "pre_rst");
        async_reset("async_rst");
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 8'(i), "stream");
            pulses += int'(ifc.valid_out);
            if (i % 4 == 0)
                check("stream.pulse_pos", {31'd0, ifc.valid_out}, 32'd1);
        end
        check("stream.word3", ifc.data_out, 32'h090A0B0C);
        check("stream.pulses", pulses, 32'd3);
        check("stream.cnt", {24'd0, ifc.word_count}, 32'd3);

        // Mid-group gap followed directly by a new group
        step(1'b1, 8'h11, "gap");
        step(1'b1, 8'h22, "gap");
        step(1'b0, 8'h00, "gap.idle");
        check("gap.pd", {31'd0, ifc.partial_drop}, 32'd1);
        check("gap.hold", ifc.data_out, 32'h090A0B0C);
        step(1'b1, 8'h33, "gap");
        step(1'b1, 8'h44, "gap");
        step(1'b1, 8'h55, "gap");
        check("gap.hold2", ifc.data_out, 32'h090A0B0C);
        step(1'b1, 8'h66, "gap");
        check("gap.word", ifc.data_out, 32'h33445566);

        // Reset in the middle of a group
        step(1'b1, 8'h01, "rstmid");
        step(1'b1, 8'h02, "rstmid");
        step(1'b1, 8'h03, "rstmid");
        async_reset("rstmid.rst");
        step(1'b1, 8'hA1, "rstmid.after");
        check("rstmid.no_pd", {31'd0, ifc.partial_drop}, 32'd0);
        step(1'b1, 8'hA2, "rstmid.after");
        step(1'b1, 8'hA3, "rstmid.after");
        step(1'b1, 8'hA4, "rstmid.after");
        check("rstmid.word", ifc.data_out, 32'hA1A2A3A4);

        // Counter wrap
        async_reset("wrap.rst");
        pulses = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 8'($urandom), "wrap");
            pulses += int'(ifc.valid_out);
        end
        check("wrap.pulses", pulses, 32'd256);
        check("wrap.cnt0", {24'd0, ifc.word_count}, 32'd0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'($urandom), "wrap.more");
        check("wrap.cnt1", {24'd0, ifc.word_count}, 32'd1);

        // Random traffic with gaps
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
